// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared riscv types: default register address/word widths, read-port count, sweep states
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] addr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam int REGFILE_NREAD = 2;

  typedef enum logic {
    SWEEP_IDLE  = 1'b0,
    SWEEP_CLEAR = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file bus: clear/ready handshake, read ports and write port
interface regfile_mp_if
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(word_t),
  parameter int ADDR_WIDTH = $bits(addr_t),
  parameter int NREAD      = REGFILE_NREAD
);

  logic                                clear;
  logic                                ready;
  logic [NREAD-1:0][ADDR_WIDTH-1:0]    raddr;
  logic [NREAD-1:0][DATA_WIDTH-1:0]    rdata;
  logic                                wen;
  logic [ADDR_WIDTH-1:0]               waddr;
  logic [DATA_WIDTH-1:0]               wdata;

  modport master (
    output clear, raddr, wen, waddr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  clear, raddr, wen, waddr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/regfile_mp_sweep.sv
// rtl/regfile_mp_sweep.sv - regfile_sweep: clear-sweep FSM zeroing one entry per cycle from 1 to all-ones
module regfile_sweep
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = $bits(addr_t)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  ready,
  output logic                  sweep_en,
  output logic [ADDR_WIDTH-1:0] sweep_addr
);

  sweep_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // reset behaves exactly like a clear request: enter the sweep at entry 1
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP_CLEAR;
      cnt_q   <= ADDR_WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    sweep_en = 1'b0;
    unique case (state_q)
      SWEEP_IDLE: begin
        ready = 1'b1;
        if (clear) begin
          state_d = SWEEP_CLEAR;
          cnt_d   = ADDR_WIDTH'(1);
        end
      end
      SWEEP_CLEAR: begin
        sweep_en = 1'b1;
        // terminal compare on all-ones so the counter never wraps
        if (clear) begin
          cnt_d = ADDR_WIDTH'(1);
        end else if (cnt_q == '1) begin
          state_d = SWEEP_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = SWEEP_CLEAR;
        cnt_d   = ADDR_WIDTH'(1);
      end
    endcase
  end

  assign sweep_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with x0 hardwired zero and clear sweep; REGFILE_BYPASS_EN adds write-to-read forwarding
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(word_t),
  parameter int ADDR_WIDTH = $bits(addr_t),
  parameter int NREAD      = REGFILE_NREAD
) (
  input  logic       clk,
  input  logic       reset,
  regfile_mp_if.slave bus
);

  localparam int NUM_ENTRIES = (1 << ADDR_WIDTH) - 1;

  logic [DATA_WIDTH-1:0]            mem_q [NUM_ENTRIES];
  logic                             ready;
  logic                             sweep_en;
  logic [ADDR_WIDTH-1:0]            sweep_addr;
  logic                             wr_commit;
  logic [NREAD-1:0][DATA_WIDTH-1:0] rdata_d;

  // address a lives in entry a-1; address 0 has no storage
  function automatic logic [ADDR_WIDTH-1:0] entry_of(input logic [ADDR_WIDTH-1:0] a);
    return a - ADDR_WIDTH'(1);
  endfunction

  regfile_sweep #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .clear      (bus.clear),
    .ready      (ready),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr)
  );

  assign bus.ready = ready;

  // a write coinciding with clear or reset is dropped in favour of the sweep
  assign wr_commit = bus.wen && ready && (bus.waddr != '0) && !bus.clear && !reset;

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      mem_q[entry_of(sweep_addr)] <= '0;
    end else if (wr_commit) begin
      mem_q[entry_of(bus.waddr)] <= bus.wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ready && (bus.raddr[i] != '0)) begin
        rdata_d[i] = mem_q[entry_of(bus.raddr[i])];
`ifdef REGFILE_BYPASS_EN
        if (bus.wen && (bus.waddr != '0) && (bus.raddr[i] == bus.waddr)) begin
          rdata_d[i] = bus.wdata;
        end
`endif
      end
    end
  end

  assign bus.rdata = rdata_d;

endmodule
